// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: FSM states, the
// reserved opcode, flag bit positions and a small one-hot helper.
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Reserved opcode: ALU is still driven but the response is forced to zero.
  localparam logic [1:0] OP_RES = 2'b11;

  // Flag vector layout, shared by the ALU and the response channel.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_W = 3;

  // One-hot select for a two-requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two requesters and the ALU sharing
// controller. Requester i uses bit i of the valid/ready vectors and slice i
// of the packed op/operand buses.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32
) ();
  import alu_share_ctrl_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic [FLAG_W-1:0]  rsp_flags;
  logic               rsp_err;

  // Requester side.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is chosen; last_grant starts at 1 so requester 0 wins the first
// tie. The grant is combinational; history advances only on accept.
module rr_arb2
  import alu_share_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_grant;

  // Winner selection from the current requests and the grant history.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    grant_idx = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
    grant = (req == 2'b00) ? 2'b00 : onehot2(grant_idx);
  end

  // Remember who was granted on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. An accepted request
// is registered, presented to the ALU for one cycle, and the captured
// result/flags are returned to the winner on a valid/ready channel.
// Optional feature: define ALU_SHARE_PERF_EN to enable the saturating
// per-requester grant counters; otherwise they read as zero.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.slave   bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_op,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  state_t           state;
  logic             grant_q;
  logic [1:0]       arb_grant;
  logic             arb_idx;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .accept    (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // A request is taken whenever we are idle and anyone is asking.
  assign accept = (state == ST_IDLE) && (bus.req_valid != 2'b00);

  // Ready follows the arbiter only while idle; held low during reset.
  assign bus.req_ready = (rst_n && state == ST_IDLE) ? arb_grant : 2'b00;

  // Pick the winning requester's op and operands.
  always_comb begin
    sel_op = bus.req_op[1:0];
    sel_a  = bus.req_a[WIDTH-1:0];
    sel_b  = bus.req_b[WIDTH-1:0];
    if (arb_idx) begin
      sel_op = bus.req_op[3:2];
      sel_a  = bus.req_a[2*WIDTH-1:WIDTH];
      sel_b  = bus.req_b[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM: latch on accept, capture ALU in ISSUE, hold in RESP.
  // The ALU operand registers double as the operand latch, so the ALU inputs
  // only change on accept and stay put through ISSUE and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      grant_q        <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= 2'b00;
      bus.rsp_valid  <= 2'b00;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant_q <= arb_idx;
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_op  <= sel_op;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (alu_op == OP_RES) begin
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
            bus.rsp_err    <= 1'b1;
          end else begin
            bus.rsp_result <= alu_result;
            bus.rsp_flags  <= alu_flags;
            bus.rsp_err    <= 1'b0;
          end
          bus.rsp_valid <= onehot2(grant_q);
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[grant_q]) begin
            bus.rsp_valid <= 2'b00;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_PERF_EN
  // Saturating count of accepted requests per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!arb_idx && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (arb_idx && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl. A behavioural ALU drives the DUT's
// ALU port; a transaction-level model of the controller predicts every
// output each cycle, and directed scenarios pin the model with literals.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef ALU_SHARE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(WIDTH)) bus ();
  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]        alu_op;
  logic [FLAG_W-1:0] alu_flags;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  alu_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: 00 add, 01 sub, 10 and, 11 or. Returns {flags, result}.
  function automatic logic [FLAG_W+WIDTH-1:0] alu_fn(input logic [1:0] op,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
    logic [WIDTH:0]    s;
    logic [WIDTH-1:0]  r;
    logic [FLAG_W-1:0] f;
    s = '0;
    f = '0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0];
        f[FLAG_C] = s[WIDTH];
        f[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[WIDTH-1:0];
        f[FLAG_C] = s[WIDTH];
        f[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    f[FLAG_Z] = (r == '0);
    return {f, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  // Round-robin rule: a lone requester wins; on a tie the one not last granted.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // ---------------- Reference model (transaction level) ----------------
  bit                m_busy = 1'b0;
  int                m_age = 0;        // cycles since the in-flight op was accepted
  bit                m_who = 1'b0;
  logic [1:0]        m_op = 2'b00;
  logic [WIDTH-1:0]  m_a = '0, m_b = '0;
  bit                m_last = 1'b1;
  logic [WIDTH-1:0]  m_result = '0;
  logic [FLAG_W-1:0] m_flags = '0;
  bit                m_err = 1'b0;
  int                m_cnt0 = 0, m_cnt1 = 0;
  logic [1:0]        m_pick;
  logic [FLAG_W+WIDTH-1:0] m_calc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_who = 1'b0; m_op = 2'b00; m_a = '0; m_b = '0;
      m_last = 1'b1; m_result = '0; m_flags = '0; m_err = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (!m_busy) begin
      if (bus.req_valid != 2'b00) begin
        m_pick = rr_pick(bus.req_valid, m_last);
        m_who  = m_pick[1];
        m_last = m_who;
        m_op   = bus.req_op[2*m_who +: 2];
        m_a    = bus.req_a[WIDTH*m_who +: WIDTH];
        m_b    = bus.req_b[WIDTH*m_who +: WIDTH];
        m_busy = 1'b1;
        m_age  = 0;
        if (PERF && !m_who && m_cnt0 < SAT) m_cnt0++;
        if (PERF && m_who && m_cnt1 < SAT)  m_cnt1++;
      end
    end else if (m_age == 0) begin
      m_calc = alu_fn(m_op, m_a, m_b);
      if (m_op == OP_RES) begin
        m_result = '0; m_flags = '0; m_err = 1'b1;
      end else begin
        m_result = m_calc[WIDTH-1:0];
        m_flags  = m_calc[FLAG_W+WIDTH-1:WIDTH];
        m_err    = 1'b0;
      end
      m_age = 1;
    end else if (bus.rsp_ready[m_who]) begin
      m_busy = 1'b0;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [1:0] exp_ready, exp_valid;
    exp_ready = (!rst_n || m_busy) ? 2'b00 : rr_pick(bus.req_valid, m_last);
    exp_valid = (m_busy && m_age == 1) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready",  bus.req_ready,  exp_ready);
    check("rsp_valid",  bus.rsp_valid,  exp_valid);
    check("rsp_result", bus.rsp_result, m_result);
    check("rsp_flags",  bus.rsp_flags,  m_flags);
    check("rsp_err",    bus.rsp_err,    m_err);
    check("alu_a",      alu_a,          m_a);
    check("alu_b",      alu_b,          m_b);
    check("alu_op",     alu_op,         m_op);
    check("grant_cnt0", grant_cnt0,     m_cnt0[CNT_W-1:0]);
    check("grant_cnt1", grant_cnt1,     m_cnt1[CNT_W-1:0]);
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_op[2*i +: 2]     = op;
    bus.req_a[WIDTH*i +: WIDTH] = a;
    bus.req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // Returns at the negedge where a handshake is visible; accept is the next posedge.
  task automatic wait_accept(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != 2'b00) begin
        g = bus.req_valid & bus.req_ready;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: no handshake within 50 cycles at %0t", $time);
  endtask

  task automatic directed_op(input string tag, input bit who, input logic [1:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] exp_r, input logic [2:0] exp_f,
                             input bit exp_e);
    logic [1:0] g, want;
    want = who ? 2'b10 : 2'b01;
    step();
    set_req(who, op, a, b);
    bus.req_valid = want;
    bus.rsp_ready = 2'b11;
    wait_accept(g);
    check({tag, "_grant"}, g, want);
    step();                      // ISSUE cycle
    bus.req_valid = 2'b00;
    @(negedge clk);
    check({tag, "_alu_op"}, alu_op, op);
    check({tag, "_alu_a"},  alu_a,  a);
    step();                      // RESP cycle: two cycles after accept
    @(negedge clk);
    check({tag, "_rsp_valid"}, bus.rsp_valid,  want);
    check({tag, "_result"},    bus.rsp_result, exp_r);
    check({tag, "_flags"},     bus.rsp_flags,  exp_f);
    check({tag, "_err"},       bus.rsp_err,    exp_e);
  endtask

  function automatic logic [WIDTH-1:0] pick_data();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7fff_ffff;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Scenarios ----------------
  initial begin
    logic [1:0] g;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", bus.req_ready, 2'b00);
    check("reset_rsp_valid", bus.rsp_valid, 2'b00);
    step();
    rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate starting with 0.
    bus.rsp_ready = 2'b11;
    set_req(0, 2'b00, 32'd1, 32'd1);
    set_req(1, 2'b01, 32'd9, 32'd4);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_accept(g);
      check($sformatf("tie_order_%0d", k), g, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    step();
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("tie_cnt0", grant_cnt0, PERF ? 2 : 0);
    check("tie_cnt1", grant_cnt1, PERF ? 2 : 0);

    // Single requester ops with hand-computed results.
    directed_op("add_2_3",   1'b0, 2'b00, 32'd2,          32'd3, 32'd5,          3'b000, 1'b0);
    directed_op("add_wrap",  1'b0, 2'b00, 32'hffff_ffff,  32'd1, 32'd0,          3'b011, 1'b0);
    directed_op("add_ovf",   1'b1, 2'b00, 32'h7fff_ffff,  32'd1, 32'h8000_0000,  3'b100, 1'b0);
    directed_op("res_op",    1'b1, 2'b11, 32'd5,          32'd6, 32'd0,          3'b000, 1'b1);

    // Response stall: hold rsp_ready low with another request pending.
    step();
    bus.rsp_ready = 2'b00;
    set_req(0, 2'b01, 32'd10, 32'd3);
    bus.req_valid = 2'b01;
    wait_accept(g);
    check("stall_grant", g, 2'b01);
    step();
    set_req(1, 2'b10, 32'hf0f0, 32'h0ff0);
    bus.req_valid = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rsp_valid", bus.rsp_valid,  2'b01);
      check("stall_result",    bus.rsp_result, 32'd7);
      check("stall_req_ready", bus.req_ready,  2'b00);
    end
    step();
    bus.rsp_ready = 2'b10;       // wrong requester's ready must be ignored
    @(negedge clk);
    check("stall_ignore_other", bus.rsp_valid, 2'b01);
    step();
    bus.rsp_ready = 2'b11;
    wait_accept(g);
    check("stall_next_grant", g, 2'b10);
    step();
    bus.req_valid = 2'b00;

    // Reset pulse during ISSUE aborts; afterwards the tie goes to requester 0.
    step();
    bus.req_valid = 2'b11;
    wait_accept(g);
    step();                      // ISSUE cycle
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", bus.rsp_valid, 2'b00);
    check("abort_alu_a",     alu_a,         32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_tie", bus.req_ready, 2'b01);
    wait_accept(g);
    step();
    bus.req_valid = 2'b00;

    // Counter saturation: five more accepts from requester 0.
    for (int k = 1; k <= 5; k++)
      directed_op($sformatf("sat_%0d", k), 1'b0, 2'b00, k, k, 2 * k, 3'b000, 1'b0);
    @(negedge clk);
    check("sat_cnt0", grant_cnt0, PERF ? 3 : 0);
    check("sat_cnt1", grant_cnt1, 0);

    // Randomized traffic with withdrawals and response back-pressure.
    for (int c = 0; c < 1500; c++) begin
      step();
      bus.req_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++)
        set_req(i, 2'($urandom_range(0, 3)), pick_data(), pick_data());
      bus.rsp_ready[0] = ($urandom_range(0, 9) < 7);
      bus.rsp_ready[1] = ($urandom_range(0, 9) < 7);
    end
    step();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that shares the processor's single combinational ALU: 32-bit A/B, 2-bit op, result, 3-bit flags {overflow, carry, zero}. It arbitrates round-robin between requester 0 (the multi-cycle control unit's execute step) and requester 1 (the PC/address-update step). It registers operands, drives the ALU for one cycle, captures result and flags, and returns them to the winner over a valid/ready response channel. It sits between the control FSM and the ALU instance in the datapath.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of each grant counter (only with ALU_SHARE_PERF_EN)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept
- req_op  in  4  op of requester i at [2i+1:2i]
- req_a  in  2*WIDTH  operand A of requester i at [WIDTH*i +: WIDTH]
- req_b  in  2*WIDTH  operand B, same packing
- rsp_valid  out  2  one-hot response valid to granted requester
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  WIDTH  captured ALU result
- rsp_flags  out  3  captured flags: [0] zero, [1] carry, [2] overflow
- rsp_err  out  1  set when the served op was 2'b11 (reserved)
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_op  out  2  ALU opcode
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_flags  in  3  ALU flags, same bit order as rsp_flags
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-request counts

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: req_ready = grant one-hot if any req_valid, else 0. The handshake (valid & ready) latches op/A/B and grant index, then moves to ISSUE.
- Arbitration: if only one requester is valid, it wins. If both are valid, the requester not in last_grant wins. last_grant resets to 1, so requester 0 wins the first tie. last_grant updates on every accept.
- ISSUE: alu_a/alu_b/alu_op are driven from the operand registers. At the clock edge, alu_result/alu_flags are captured into the response registers and the FSM moves to RESP.
- Op 2'b11: the ALU is still driven, but the captured result is 0, flags are 3'b000, and rsp_err = 1.
- RESP: rsp_valid[grant] = 1, and result/flags/err are held stable. On rsp_ready[grant], the FSM returns to IDLE. rsp_ready of the non-granted requester is ignored.
- Outside ISSUE, alu_a/alu_b/alu_op hold the last-issued values. They never change mid-ISSUE.
- req_ready is 0 in ISSUE and RESP. A requester keeps req_valid asserted until accepted.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_result 0, rsp_flags 0, rsp_err 0, alu_a/alu_b 0, alu_op 0, grant counters 0, last_grant 1.
- Accept at edge N → ISSUE during cycle N+1 → rsp_valid high in cycle N+2.
- Minimum 3 cycles per op when rsp_ready is already high. Next accept occurs in the first IDLE cycle after the response handshake.
- The response may stall indefinitely; all outputs are held meanwhile.
- An rst_n assertion in any state aborts the op immediately. No response is produced for it, and all outputs return to reset values.
- A req_valid deasserted before acceptance is legal (request withdrawn).

## Configuration
- ALU_SHARE_PERF_EN defined: grant_cnt0/grant_cnt1 increment on each accept of the respective requester and saturate at all-ones.
- Not defined: the counter logic is removed and both ports are tied to 0. Ports are present in both builds.

## Structure
- Shared package: FSM state enum, op constants (OP_RES = 2'b11), and flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_V=2.
- One sub-module: rr_arb2, a 2-input round-robin arbiter with last_grant state and a one-hot grant output.

## Test plan
- Requester 0 only: op 00, A=2, B=3 → rsp_valid=01 two cycles after accept, rsp_result = alu_result for those inputs, flags match the ALU.
- Both valid every cycle for 4 ops → grants in order 0,1,0,1; grant_cnt0 = grant_cnt1 = 2 when ALU_SHARE_PERF_EN is defined.
- Response stall: rsp_ready low for 5 cycles → rsp_valid and rsp_result stable, req_ready = 00 throughout.
- Op 2'b11 from requester 1 → rsp_valid=10, rsp_err=1, rsp_result=0, rsp_flags=000.
- rst_n pulsed low during ISSUE → all outputs take reset values; after release, a pending tie is granted to requester 0.
- Counter saturation with CNT_W=2: 5 accepts from requester 0 → grant_cnt0=3.
